alu_arbiter: RTL and testbench

- Shares the single combinational `ALU` between two requesters: port 0 is the execute stage and port 1 is the branch/compare unit.
- Each request port uses a valid/ready handshake.
- Grants are round-robin.
- The ALU result is registered once and returned on per-port response handshakes.
- Throughput is one operation per cycle when there is no back-pressure.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_arbiter_alu.sv | 42 ++++
 rtl/alu_arbiter.sv | 110 +++++++++++
 tb/tb_alu_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths and operation codes.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] ADD                        = 4'd0;
  localparam logic [OP_W-1:0] SUB                        = 4'd1;
  localparam logic [OP_W-1:0] OR                         = 4'd2;
  localparam logic [OP_W-1:0] XOR                        = 4'd3;
  localparam logic [OP_W-1:0] AND                        = 4'd4;
  localparam logic [OP_W-1:0] LesserThanUnsigned         = 4'd5;
  localparam logic [OP_W-1:0] LesserThanSigned           = 4'd6;
  localparam logic [OP_W-1:0] ShiftRightUnsigned         = 4'd7;
  localparam logic [OP_W-1:0] ShiftLeftUnsigned          = 4'd8;
  localparam logic [OP_W-1:0] ShiftRightSigned           = 4'd9;
  localparam logic [OP_W-1:0] ShiftLeftSigned            = 4'd10;
  localparam logic [OP_W-1:0] GreaterThanOrEqualUnsigned = 4'd11;
  localparam logic [OP_W-1:0] GreaterThanOrEqualSigned   = 4'd12;
  localparam logic [OP_W-1:0] Equal                      = 4'd13;
  localparam logic [OP_W-1:0] NotEqual                   = 4'd14;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational ALU shared by the execute stage and branch unit.
// Compare operations return 0/1 in the LSB; shifts use the low log2(XLEN) bits of B.
module ALU #(
  parameter int XLEN = alu_pkg::XLEN,
  parameter int OP_W = alu_pkg::OP_W
) (
  input  logic [OP_W-1:0] Operation,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic [XLEN-1:0] Out
);
  import alu_pkg::*;

  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] shamt;
  assign shamt = B[SH_W-1:0];

  // Operation decode
  always_comb begin
    Out = '0;
    case (Operation)
      ADD:                        Out = A + B;
      SUB:                        Out = A - B;
      OR:                         Out = A | B;
      XOR:                        Out = A ^ B;
      AND:                        Out = A & B;
      LesserThanUnsigned:         Out = {{(XLEN-1){1'b0}}, (A < B)};
      LesserThanSigned:           Out = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
      ShiftRightUnsigned:         Out = A >> shamt;
      ShiftLeftUnsigned:          Out = A << shamt;
      ShiftRightSigned:           Out = $unsigned($signed(A) >>> shamt);
      ShiftLeftSigned:            Out = A << shamt;
      GreaterThanOrEqualUnsigned: Out = {{(XLEN-1){1'b0}}, (A >= B)};
      GreaterThanOrEqualSigned:   Out = {{(XLEN-1){1'b0}}, ($signed(A) >= $signed(B))};
      Equal:                      Out = {{(XLEN-1){1'b0}}, (A == B)};
      NotEqual:                   Out = {{(XLEN-1){1'b0}}, (A != B)};
      default:                    Out = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a single shared ALU.
// Result is registered once and handed back on per-port response handshakes.
// Optional build macro ALU_ARB_STATS_EN adds grant/stall counters.
module alu_arbiter #(
  parameter int XLEN = alu_pkg::XLEN,
  parameter int OP_W = alu_pkg::OP_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OP_W-1:0] req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OP_W-1:0] req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
`ifdef ALU_ARB_STATS_EN
  output logic [31:0]     grant0_cnt,
  output logic [31:0]     grant1_cnt,
  output logic [31:0]     stall_cnt,
`endif
  output logic [XLEN-1:0] rsp_data
);
  import alu_pkg::*;

  logic            res_valid;
  logic            res_owner;
  logic [XLEN-1:0] res_data;
  logic            prio;

  logic [1:0]      req_valid;
  logic [1:0]      rsp_ready;
  logic            can_accept;
  logic            gnt_valid;
  logic            gnt;
  logic            accept;
  logic [OP_W-1:0] mux_op;
  logic [XLEN-1:0] mux_a;
  logic [XLEN-1:0] mux_b;
  logic [XLEN-1:0] alu_out;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // Round-robin pick and operand mux; slot frees when empty or draining this cycle
  always_comb begin
    can_accept = !res_valid || rsp_ready[res_owner];
    gnt_valid  = |req_valid;
    gnt        = (req_valid == 2'b11) ? prio : req_valid[1];
    accept     = can_accept && gnt_valid && !reset;
    mux_op     = gnt ? req1_op : req0_op;
    mux_a      = gnt ? req1_a  : req0_a;
    mux_b      = gnt ? req1_b  : req0_b;
  end

  assign req0_ready = accept && !gnt;
  assign req1_ready = accept &&  gnt;

  // Outputs are forced quiet while reset is asserted so a held result never leaks
  assign rsp0_valid = res_valid && !res_owner && !reset;
  assign rsp1_valid = res_valid &&  res_owner && !reset;
  assign rsp_data   = reset ? '0 : res_data;

  ALU #(.XLEN(XLEN), .OP_W(OP_W)) u_alu (
    .Operation (mux_op),
    .A         (mux_a),
    .B         (mux_b),
    .Out       (alu_out)
  );

  // Result register: reload on accept (even while draining), clear on bare drain
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_owner <= 1'b0;
      res_data  <= '0;
      prio      <= 1'b0;
    end else if (accept) begin
      res_valid <= 1'b1;
      res_owner <= gnt;
      res_data  <= alu_out;
      prio      <= ~gnt;
    end else if (res_valid && rsp_ready[res_owner]) begin
      res_valid <= 1'b0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Grant and stall statistics, free-running modulo 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      grant0_cnt <= '0;
      grant1_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (accept && !gnt)       grant0_cnt <= grant0_cnt + 32'd1;
      if (accept &&  gnt)       grant1_cnt <= grant1_cnt + 32'd1;
      if (gnt_valid && !accept) stall_cnt  <= stall_cnt  + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: driver pushes expected responses, a
// negedge monitor pops and compares on every response handshake.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp_data;
`ifdef ALU_ARB_STATS_EN
  logic [31:0] grant0_cnt, grant1_cnt, stall_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];

  alu_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
`ifdef ALU_ARB_STATS_EN
    .grant0_cnt (grant0_cnt),
    .grant1_cnt (grant1_cnt),
    .stall_cnt  (stall_cnt),
`endif
    .rsp_data   (rsp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic set1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  task automatic chk_rdy(input string name, input logic r0, input logic r1);
    chk({name, "_rdy0"}, {31'd0, req0_ready}, {31'd0, r0});
    chk({name, "_rdy1"}, {31'd0, req1_ready}, {31'd0, r1});
  endtask

  // Monitor: every completed response handshake must match the head of the queue
  always @(negedge clk) begin
    logic [32:0] e;
    if (rsp0_valid && rsp1_valid) chk("rsp_both_valid", 32'd1, 32'd0);
    if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", {31'd0, rsp1_valid}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_port", {31'd0, rsp1_valid}, {31'd0, e[32]});
        chk("rsp_data", rsp_data, e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic g, pg;
    reset = 1'b1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    set0(1'b1, ADD, 32'd5, 32'd7);
    set1(1'b1, Equal, 32'd4, 32'd4);

    // 1: reset held 3 cycles with both ports requesting
    for (int i = 0; i < 3; i++) begin
      cyc(); #3;
      chk_rdy("rst", 1'b0, 1'b0);
      chk("rst_rsp0v", {31'd0, rsp0_valid}, 32'd0);
      chk("rst_rsp1v", {31'd0, rsp1_valid}, 32'd0);
      chk("rst_data", rsp_data, 32'd0);
    end
    cyc(); reset = 1'b0; #3;
    chk_rdy("rel", 1'b1, 1'b0);
    chk("rel_rsp0v", {31'd0, rsp0_valid}, 32'd0);
    chk("rel_data", rsp_data, 32'd0);
    exp_q.push_back({1'b0, 32'd12});

    // 2: port 0 alone, ADD 5+7 (granted even though prio now points at port 1)
    cyc(); set1(1'b0, Equal, 32'd4, 32'd4); #3;
    chk_rdy("solo", 1'b1, 1'b0);
    chk("solo_rsp0v", {31'd0, rsp0_valid}, 32'd1);
    chk("solo_rsp1v", {31'd0, rsp1_valid}, 32'd0);
    chk("solo_data", rsp_data, 32'd12);
    exp_q.push_back({1'b0, 32'd12});

    // 3: both ports continuously; prio=1 so grants go 1,0,1,0
    pg = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 0) begin
        set0(1'b1, SUB, 32'd10, 32'd3);
        set1(1'b1, Equal, 32'd4, 32'd4);
      end
      #3;
      g = (i % 2 == 0);
      chk_rdy("rr", !g, g);
      if (i > 0) begin
        chk("rr_data", rsp_data, pg ? 32'd1 : 32'd7);
        chk("rr_rsp1v", {31'd0, rsp1_valid}, {31'd0, pg});
      end
      exp_q.push_back({g, g ? 32'd1 : 32'd7});
      pg = g;
    end

    // 4: back-pressure on port 1 result
    cyc();
    set0(1'b0, ADD, 32'd0, 32'd0);
    set1(1'b1, ShiftRightSigned, 32'h8000_0000, 32'd4);
    rsp1_ready = 1'b0;
    #3;
    chk_rdy("bp_acc", 1'b0, 1'b1);
    chk("bp_prev_data", rsp_data, 32'd7);
    exp_q.push_back({1'b1, 32'hF800_0000});
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 0) begin
        set1(1'b0, ADD, 32'd0, 32'd0);
        set0(1'b1, OR, 32'hF0, 32'h0F);
      end
      #3;
      chk_rdy("bp_hold", 1'b0, 1'b0);
      chk("bp_rsp1v", {31'd0, rsp1_valid}, 32'd1);
      chk("bp_data", rsp_data, 32'hF800_0000);
    end
    cyc(); rsp1_ready = 1'b1; #3;
    chk_rdy("bp_release", 1'b1, 1'b0);
    exp_q.push_back({1'b0, 32'hFF});

    // 5: reset right after accepting XOR; that result must never appear
    cyc(); set0(1'b1, XOR, 32'hFF, 32'h0F); #3;
    chk_rdy("xor_acc", 1'b1, 1'b0);
    chk("xor_prev_data", rsp_data, 32'hFF);
    cyc(); reset = 1'b1; set0(1'b0, ADD, 32'd0, 32'd0); #3;
    chk_rdy("mid_rst", 1'b0, 1'b0);
    chk("mid_rst_rsp0v", {31'd0, rsp0_valid}, 32'd0);
    chk("mid_rst_data", rsp_data, 32'd0);

    // 6: after reset prio=0, four alternating grants then two stalls
    cyc(); reset = 1'b0;
    set0(1'b1, ADD, 32'd1, 32'd1);
    set1(1'b1, ADD, 32'd2, 32'd2);
    #3;
    chk("post_rst_rsp0v", {31'd0, rsp0_valid}, 32'd0);
    chk("post_rst_rsp1v", {31'd0, rsp1_valid}, 32'd0);
    chk("post_rst_data", rsp_data, 32'd0);
`ifdef ALU_ARB_STATS_EN
    chk("cnt_g0_rst", grant0_cnt, 32'd0);
    chk("cnt_g1_rst", grant1_cnt, 32'd0);
    chk("cnt_st_rst", stall_cnt, 32'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin cyc(); #3; end
      g = (i % 2 == 1);
      chk_rdy("st_rr", !g, g);
      exp_q.push_back({g, g ? 32'd4 : 32'd2});
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      rsp1_ready = 1'b0;
      set1(1'b0, ADD, 32'd0, 32'd0);
      #3;
      chk_rdy("stall", 1'b0, 1'b0);
      chk("stall_data", rsp_data, 32'd4);
    end
    cyc(); set0(1'b0, ADD, 32'd0, 32'd0); rsp1_ready = 1'b1; #3;
    chk("drain_rsp1v", {31'd0, rsp1_valid}, 32'd1);
`ifdef ALU_ARB_STATS_EN
    chk("cnt_g0", grant0_cnt, 32'd2);
    chk("cnt_g1", grant1_cnt, 32'd2);
    chk("cnt_stall", stall_cnt, 32'd2);
`endif
    cyc(); #3;
    chk("idle_rsp0v", {31'd0, rsp0_valid}, 32'd0);
    chk("idle_rsp1v", {31'd0, rsp1_valid}, 32'd0);
    chk("queue_left", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
